// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table response checker: state encoding,
// default sweep geometry and expected-output tables of the AND_inciso designs.
package tt_pkg;

  localparam int unsigned TT_NIN  = 5;
  localparam int unsigned TT_NOUT = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    CMP_LAST = 2'd2,
    DONE     = 2'd3
  } tt_state_e;

  // Table layout: vector v = {X,Y,Z,K,M} occupies bits [2*v +: 2], bit0 = S_OR, bit1 = out_7.
  function automatic logic [63:0] tt_and_inciso2_table();
    logic [63:0] t;
    logic [4:0]  v;
    logic [5:0]  b;
    t = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      v = i[4:0];
      b = {v, 1'b0};
      t[b +: 2] = {&v, |v};
    end
    return t;
  endfunction

  function automatic logic [63:0] tt_and_inciso3_table();
    logic [63:0] t;
    logic [4:0]  v;
    logic [5:0]  b;
    t = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      v = i[4:0];
      b = {v, 1'b0};
      t[b +: 2] = {v[4] & v[3] & v[2], (v[4] & v[3]) | (v[2] & v[1] & v[0])};
    end
    return t;
  endfunction

  localparam logic [63:0] TT_EXP_AND_INCISO2 = tt_and_inciso2_table();
  localparam logic [63:0] TT_EXP_AND_INCISO3 = tt_and_inciso3_table();

endpackage

// File: rtl/tt_expect_lut.sv
// Combinational index -> expected-output lookup over a packed truth table.
module tt_expect_lut
  import tt_pkg::*;
#(
  parameter int unsigned                   NIN       = TT_NIN,
  parameter int unsigned                   NOUT      = TT_NOUT,
  parameter logic [NOUT*(2**NIN)-1:0]      EXP_TABLE = '0
) (
  input  logic [NIN-1:0]  i_idx,
  output logic [NOUT-1:0] o_exp
);

  logic [NOUT-1:0] w_tab [2**NIN];

  for (genvar g = 0; g < 2**NIN; g++) begin : g_tab
    assign w_tab[g] = EXP_TABLE[g*NOUT +: NOUT];
  end

  assign o_exp = w_tab[i_idx];

endmodule

// File: rtl/tt_response_checker.sv
// Checks observed outputs of a 2^NIN-vector truth-table sweep against EXP_TABLE,
// counting mismatches, latching the first failing index and flagging order errors.
module tt_response_checker
  import tt_pkg::*;
#(
  parameter int unsigned              NIN       = TT_NIN,
  parameter int unsigned              NOUT      = TT_NOUT,
  parameter logic [NOUT*(2**NIN)-1:0] EXP_TABLE = '0,
  parameter int unsigned              CNT_W     = NIN + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [NIN-1:0]   vec_in,
  input  logic [NOUT-1:0]  obs_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [NIN-1:0]   first_err_idx,
  output logic             first_err_vld,
  output logic             seq_err,
  output logic             mismatch
);

  localparam logic [NIN-1:0]   LAST_IDX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  tt_state_e        r_state;
  logic [NIN-1:0]   r_idx;
  logic             r_vec_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_err_count;
  logic [NIN-1:0]   r_first_err_idx;
  logic             r_first_err_vld;
  logic             r_seq_err;
  logic             r_mismatch;

  logic [NOUT-1:0]  w_exp;
  logic             w_hs;
  logic             w_obs_fail;
  logic             w_seq_fail;

  tt_expect_lut #(
    .NIN       (NIN),
    .NOUT      (NOUT),
    .EXP_TABLE (EXP_TABLE)
  ) u_lut (
    .i_idx (r_idx),
    .o_exp (w_exp)
  );

  // Expected value is indexed by the counter, not vec_in, so an order error
  // never masks or fakes an output mismatch.
  always_comb begin
    w_hs       = vec_valid && r_vec_ready;
    w_obs_fail = (obs_in != w_exp);
    w_seq_fail = (vec_in != r_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_idx           <= '0;
      r_vec_ready     <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_err_count     <= '0;
      r_first_err_idx <= '0;
      r_first_err_vld <= 1'b0;
      r_seq_err       <= 1'b0;
      r_mismatch      <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state         <= RUN;
            r_idx           <= '0;
            r_vec_ready     <= 1'b1;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_first_err_vld <= 1'b0;
            r_seq_err       <= 1'b0;
          end
        end
        RUN: begin
          // The comparison is registered on the handshake edge itself.
          if (w_hs) begin
            r_idx <= r_idx + 1'b1;
            if (w_seq_fail) begin
              r_seq_err <= 1'b1;
            end
            if (w_obs_fail) begin
              r_mismatch <= 1'b1;
              if (r_err_count != CNT_MAX) begin
                r_err_count <= r_err_count + 1'b1;
              end
              if (!r_first_err_vld) begin
                r_first_err_idx <= r_idx;
                r_first_err_vld <= 1'b1;
              end
            end
            if (r_idx == LAST_IDX) begin
              r_state     <= CMP_LAST;
              r_vec_ready <= 1'b0;
            end
          end
        end
        CMP_LAST: begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (r_err_count == '0) && !r_seq_err;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign vec_ready     = r_vec_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err_count;
  assign first_err_idx = r_first_err_idx;
  assign first_err_vld = r_first_err_vld;
  assign seq_err       = r_seq_err;
  assign mismatch      = r_mismatch;

endmodule

// File: tb/tb_tt_response_checker.sv
// Table-driven sweeps with a per-handshake scoreboard, plus reset-abort sequence.
module tb_tt_response_checker;

  localparam int          NIN = 5;
  localparam int          NOUT = 2;
  localparam logic [63:0] TBL = 64'hFFFF_0000_AAAA_5555;

  typedef struct {
    int fa;
    int fb;
    bit swap;
    bit gaps;
    int e_err;
    bit e_fvld;
    int e_fidx;
    bit e_seq;
    bit e_pass;
  } case_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           vec_valid = 1'b0;
  logic [NIN-1:0] vec_in = '0;
  logic [NOUT-1:0] obs_in = '0;
  logic           vec_ready, busy, done, pass, first_err_vld, seq_err, mismatch;
  logic [NIN:0]   err_count;
  logic [NIN-1:0] first_err_idx;

  int total = 0;
  int bad = 0;
  int m_idx, m_err, m_fidx;
  bit m_fvld, m_seq;
  bit sb[$];
  case_t cases[5];

  always #5 clk = ~clk;

  tt_response_checker #(
    .NIN       (NIN),
    .NOUT      (NOUT),
    .EXP_TABLE (TBL),
    .CNT_W     (NIN + 1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .vec_valid     (vec_valid),
    .vec_ready     (vec_ready),
    .vec_in        (vec_in),
    .obs_in        (obs_in),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .first_err_vld (first_err_vld),
    .seq_err       (seq_err),
    .mismatch      (mismatch)
  );

  function automatic logic [1:0] exp_of(input int i);
    logic [63:0] t;
    t = TBL >> (2 * i);
    return t[1:0];
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_model();
    chk("err_count", int'(err_count), m_err);
    chk("first_err_vld", int'(first_err_vld), int'(m_fvld));
    chk("first_err_idx", int'(first_err_idx), m_fidx);
    chk("seq_err", int'(seq_err), int'(m_seq));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, int'(vec_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err"}, int'(err_count), 0);
    chk({tag, "_fidx"}, int'(first_err_idx), 0);
    chk({tag, "_fvld"}, int'(first_err_vld), 0);
    chk({tag, "_seq"}, int'(seq_err), 0);
    chk({tag, "_mm"}, int'(mismatch), 0);
  endtask

  task automatic run_sweep(input case_t c);
    int k = 0;
    int lat = 0;
    int guard = 0;
    bit hs;
    bit mm;
    bit mm_exp;
    int ov;
    m_idx = 0; m_err = 0; m_fidx = 0; m_fvld = 0; m_seq = 0;
    sb.delete();
    @(negedge clk);
    start = 1'b1;
    vec_valid = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    chk("run_entry_busy", int'(busy), 1);
    chk("run_entry_ready", int'(vec_ready), 1);
    chk("run_entry_done", int'(done), 0);
    chk("run_entry_pass", int'(pass), 0);
    chk_model();
    while (done !== 1'b1 && guard < 200) begin
      @(negedge clk);
      start = c.gaps && (guard == 10);
      if (k < 32 && (!c.gaps || (guard % 3) == 0)) begin
        ov = k;
        if (c.swap && k == 2) ov = 3;
        if (c.swap && k == 3) ov = 2;
        vec_in = 5'(ov);
        obs_in = exp_of(k) ^ ((k == c.fa || k == c.fb) ? 2'b01 : 2'b00);
        vec_valid = 1'b1;
      end else begin
        vec_valid = 1'b0;
      end
      hs = vec_valid && vec_ready;
      if (hs) begin
        mm = (obs_in != exp_of(m_idx));
        if (int'(vec_in) != m_idx) m_seq = 1'b1;
        if (mm) begin
          if (m_err < 63) m_err++;
          if (!m_fvld) begin
            m_fvld = 1'b1;
            m_fidx = m_idx;
          end
        end
        m_idx++;
        sb.push_back(mm);
      end
      @(posedge clk);
      #1;
      lat++;
      guard++;
      mm_exp = 1'b0;
      if (hs) begin
        k++;
        mm_exp = sb.pop_front();
      end
      chk("mismatch_pulse", int'(mismatch), int'(mm_exp));
      chk_model();
    end
    vec_valid = 1'b0;
    start = 1'b0;
    chk("done_seen", int'(done), 1);
    chk("handshakes", k, 32);
    if (!c.gaps) chk("done_latency", lat, 34);
    chk("sum_err", int'(err_count), c.e_err);
    chk("sum_fvld", int'(first_err_vld), int'(c.e_fvld));
    chk("sum_fidx", int'(first_err_idx), c.e_fidx);
    chk("sum_seq", int'(seq_err), int'(c.e_seq));
    chk("sum_pass", int'(pass), int'(c.e_pass));
    chk("sum_busy", int'(busy), 0);
    chk("sum_ready", int'(vec_ready), 0);
    @(posedge clk);
    #1;
    chk("done_hold", int'(done), 1);
    chk("pass_hold", int'(pass), int'(c.e_pass));
  endtask

  initial begin
    cases[0] = '{fa: -1, fb: -1, swap: 0, gaps: 0, e_err: 0, e_fvld: 0, e_fidx: 0, e_seq: 0, e_pass: 1};
    cases[1] = '{fa: 7,  fb: 20, swap: 0, gaps: 0, e_err: 2, e_fvld: 1, e_fidx: 7, e_seq: 0, e_pass: 0};
    cases[2] = '{fa: -1, fb: -1, swap: 0, gaps: 0, e_err: 0, e_fvld: 0, e_fidx: 0, e_seq: 0, e_pass: 1};
    cases[3] = '{fa: -1, fb: -1, swap: 1, gaps: 0, e_err: 0, e_fvld: 0, e_fidx: 0, e_seq: 1, e_pass: 0};
    cases[4] = '{fa: -1, fb: -1, swap: 0, gaps: 1, e_err: 0, e_fvld: 0, e_fidx: 0, e_seq: 0, e_pass: 1};

    #3;
    chk_all_zero("reset");
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 5; i++) begin
      run_sweep(cases[i]);
    end

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vec_valid = 1'b1;
      vec_in = 5'(i);
      obs_in = exp_of(i) ^ ((i == 4) ? 2'b10 : 2'b00);
      @(posedge clk);
      #1;
    end
    chk("pre_reset_busy", int'(busy), 1);
    chk("pre_reset_err", int'(err_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    #2;
    rst_n = 1'b1;
    vec_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_idle", int'(busy), 0);
    chk("post_reset_ready", int'(vec_ready), 0);
    run_sweep(cases[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
